app_channel: RTL and testbench
==============================

# app_channel

Digital control core for one Analog Photon Processor channel. It combines two functions. The channel sequencer watches the front-end comparator (`vcomp`), drives the integrator reset, and aborts over-long pulses with a programmable timeout. The analog-memory bookkeeping measures each time-over-threshold (`TOT`) pulse and stores its width, a timestamp and the 8-bit metadata in a small event memory, which downstream logic drains.

## Interface
Parameters:
- `DEPTH`, 8: number of event cells; must be a power of two.
- `TOT_W`, 8: width of the saturating TOT width counter.
- `TS_W`, 16: width of the free-running timestamp.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `resetb_full`  in  1  synchronous, active-low full reset of the whole block.
- `rst_init`  in  1  synchronous, active-high soft re-init of the sequencer only; memory is untouched.
- `vcomp`  in  1  comparator output, synchronous to `clk`.
- `timeout_enable`  in  1  enables the integration timeout.
- `timeout_threshold`  in  4  timeout length in cycles; 0 disables the timeout.
- `TOT`  in  1  time-over-threshold pulse, synchronous to `clk`.
- `metadata`  in  8  tag captured at the `TOT` rising edge.
- `rd_en`  in  1  pops one event.
- `rd_data`  out  8+TOT_W+TS_W  event word {metadata, width, timestamp}.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `count`  out  $clog2(DEPTH)+1  number of stored events.
- `full`, `empty`  out  1 each  memory status.
- `overflow`  out  1  sticky flag, set when an event is dropped.
- `int_reset`  out  1  integrator reset pulse.
- `busy`  out  1  sequencer is not in IDLE.
- `timeout_flag`  out  1  one-cycle pulse when a timeout fires.

## Operation
- Sequencer states:
  - IDLE: `vcomp`=1 → INTEG with the cycle counter set to 1.
  - INTEG: the counter increments each cycle.
    - If `vcomp`=0 → RST.
    - Else if `timeout_enable` is set, `timeout_threshold`≠0 and the counter equals the threshold → TIMEOUT.
  - RST: asserts `int_reset` for 1 cycle, then → IDLE.
  - TIMEOUT: asserts `int_reset` and `timeout_flag` for 1 cycle, then → HOLD.
  - HOLD: waits for `vcomp`=0, then → IDLE. A pulse that timed out is never re-integrated.
- `rst_init`=1 forces IDLE and clears the counter. It does not generate `int_reset`, and it takes priority over every transition.
- Timestamp: free-running `TS_W` counter starting at 0 after reset; wraps modulo 2^TS_W.
- `TOT` is registered to `TOT_q`.
  - Rising edge (`TOT & ~TOT_q`): latch `metadata` and the timestamp, set width to 1.
  - While `TOT` stays high: width increments, saturating at 2^TOT_W−1.
  - Falling edge: write {meta, width, ts}.
- Write when full: the event is dropped and `overflow` is set. `overflow` clears only on `resetb_full`.
- Read: `rd_en` while not empty pops the oldest event. `rd_en` while empty is ignored.
- Simultaneous read and write:
  - Both take effect.
  - When full, the write is accepted; no overflow.
  - When empty, only the write happens and `rd_valid`=0.

## Timing
- Reset values:
  - Sequencer in IDLE.
  - All outputs 0, except `empty`=1.
  - Counters and pointers 0.
  - `TOT_q`=1, so a `TOT` pulse already high at reset release is ignored until it falls.
- A `TOT` high for N sampled cycles stores width N. The write lands 1 cycle after the first low sample, so `count` updates then.
- Read latency is 1 cycle: `rd_data`/`rd_valid` are valid the cycle after `rd_en`. `rd_data` holds its value otherwise.
- `int_reset` rises 1 cycle after the state that triggers it is entered.
- `resetb_full` mid-pulse discards the in-progress capture and returns the sequencer to IDLE.

## Structure
- Package `app_pkg`:
  - Sequencer state enum (IDLE, INTEG, RST, TIMEOUT, HOLD).
  - Event-word field widths.
  - Default parameter constants.
- Sub-module `amem_store`: circular-buffer event memory with pointers, `count`/`full`/`empty`, `overflow`, and the registered read port.
- The sequencer, timestamp counter and TOT measurement live in the top.

## Test plan
- Reset, then `vcomp` high 5 cycles with `timeout_enable`=1, `timeout_threshold`=10 → INTEG, then 1-cycle `int_reset`, then IDLE; no `timeout_flag`.
- `vcomp` held high 20 cycles with `timeout_threshold`=10 → `timeout_flag` and `int_reset` pulse once, after 10 INTEG cycles; HOLD until `vcomp` falls; no second pulse.
- `timeout_threshold`=0, or `timeout_enable`=0, with `vcomp` high 30 cycles → no timeout; `int_reset` only after `vcomp` falls.
- `TOT` high 3 cycles with `metadata`=8'hA5 → `count`=1; `rd_en` → `rd_data`={A5, width 3, timestamp at the rising edge}, `rd_valid` 1 cycle later.
- 9 `TOT` pulses with DEPTH=8 → `full`, `overflow`=1, `count`=8; a read during a write while full → `count` stays 8, no new overflow.
- `rst_init` pulse during INTEG → IDLE next cycle with no `int_reset`; `resetb_full` during a `TOT` pulse → `empty`=1 and the pulse is ignored until `TOT` falls.

Source files
------------

// File: rtl/app_pkg.sv
// Shared types and constants for the APP channel control core.
//   - sequencer state encoding
//   - event-word field widths and default parameter values
package app_pkg;

  localparam int unsigned META_W    = 8;   // metadata tag width
  localparam int unsigned TO_W      = 4;   // timeout threshold / cycle counter width

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned TOT_W_DEF = 8;
  localparam int unsigned TS_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTEG,
    ST_RST,
    ST_TIMEOUT,
    ST_HOLD
  } seq_state_e;

  // Event word is {metadata, width, timestamp}
  function automatic int unsigned event_w(input int unsigned tot_w, input int unsigned ts_w);
    return META_W + tot_w + ts_w;
  endfunction

endpackage

// File: rtl/amem_store.sv
// Circular-buffer event memory with registered read port.
// Ports:
//   clk, rst_ni        clock, synchronous active-low reset
//   wr_en_i/wr_data_i  event write request
//   rd_en_i            pop oldest event
//   rd_data_o/rd_valid_o  popped event, valid the cycle after rd_en_i
//   count_o/full_o/empty_o  occupancy status
//   overflow_o         sticky: a write was dropped
module amem_store #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned EW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [EW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  output logic [EW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          do_rd, do_wr;

  // A read frees a slot in the same cycle, so a full buffer still accepts a concurrent write
  always_comb begin
    do_rd      = rd_en_i && !empty_q;
    do_wr      = wr_en_i && (!full_q || do_rd);
    wr_ptr_d   = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(do_wr) - CW'(do_rd);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    ovf_d      = ovf_q || (wr_en_i && !do_wr);
    rd_data_d  = do_rd ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = do_rd;
  end

  // Storage array carries no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/app_channel.sv
// Control core for one APP channel: integration sequencer with timeout,
// free-running timestamp, TOT width measurement and event memory.
// Ports:
//   clk, resetb_full     clock, synchronous active-low full reset
//   rst_init             synchronous soft re-init of the sequencer only
//   vcomp                comparator output
//   timeout_enable/timeout_threshold  integration timeout control (0 = off)
//   TOT, metadata        time-over-threshold pulse and its tag
//   rd_en                pop one event
//   rd_data/rd_valid     {metadata, width, timestamp}, valid one cycle after rd_en
//   count/full/empty/overflow  event memory status
//   int_reset/busy/timeout_flag  sequencer outputs
module app_channel
  import app_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TOT_W = TOT_W_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic                            clk,
  input  logic                            resetb_full,
  input  logic                            rst_init,
  input  logic                            vcomp,
  input  logic                            timeout_enable,
  input  logic [TO_W-1:0]                 timeout_threshold,
  input  logic                            TOT,
  input  logic [META_W-1:0]               metadata,
  input  logic                            rd_en,
  output logic [META_W+TOT_W+TS_W-1:0]    rd_data,
  output logic                            rd_valid,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow,
  output logic                            int_reset,
  output logic                            busy,
  output logic                            timeout_flag
);

  localparam int unsigned EW = event_w(TOT_W, TS_W);

  // ---------------- sequencer ----------------
  seq_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            int_reset_q, int_reset_d;
  logic            tflag_q, tflag_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vcomp) begin
          state_d = ST_INTEG;
          cnt_d   = TO_W'(1);
        end
      end
      ST_INTEG: begin
        cnt_d = cnt_q + TO_W'(1);
        if (!vcomp) begin
          state_d = ST_RST;
        end else if (timeout_enable && (timeout_threshold != '0) &&
                     (cnt_q == timeout_threshold)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_RST:     state_d = ST_IDLE;
      ST_TIMEOUT: state_d = ST_HOLD;
      // A timed-out pulse must end before a new integration can start
      ST_HOLD: begin
        if (!vcomp) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
    if (rst_init) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    // Pulses are registered, so they appear one cycle after RST/TIMEOUT is entered
    int_reset_d = (state_q == ST_RST) || (state_q == ST_TIMEOUT);
    tflag_d     = (state_q == ST_TIMEOUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetb_full) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      int_reset_q <= 1'b0;
      tflag_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      int_reset_q <= int_reset_d;
      tflag_q     <= tflag_d;
      busy_q      <= busy_d;
    end
  end

  assign int_reset    = int_reset_q;
  assign timeout_flag = tflag_q;
  assign busy         = busy_q;

  // ---------------- timestamp and TOT measurement ----------------
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              tot_q;
  logic              cap_q, cap_d;
  logic [META_W-1:0] meta_q, meta_d;
  logic [TOT_W-1:0]  width_q, width_d;
  logic [TS_W-1:0]   tsc_q, tsc_d;
  logic              wr_q, wr_d;

  // cap_q guards against writing a pulse whose rising edge was never seen
  always_comb begin
    ts_d    = ts_q + TS_W'(1);
    cap_d   = cap_q;
    meta_d  = meta_q;
    width_d = width_q;
    tsc_d   = tsc_q;
    wr_d    = 1'b0;
    if (TOT && !tot_q) begin
      cap_d   = 1'b1;
      meta_d  = metadata;
      tsc_d   = ts_q;
      width_d = TOT_W'(1);
    end else if (TOT && cap_q) begin
      if (width_q != {TOT_W{1'b1}}) begin
        width_d = width_q + TOT_W'(1);
      end
    end else if (!TOT && tot_q && cap_q) begin
      cap_d = 1'b0;
      wr_d  = 1'b1;
    end
  end

  // tot_q resets high so a pulse already in progress at reset release is ignored
  always_ff @(posedge clk) begin
    if (!resetb_full) begin
      ts_q    <= '0;
      tot_q   <= 1'b1;
      cap_q   <= 1'b0;
      meta_q  <= '0;
      width_q <= '0;
      tsc_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      tot_q   <= TOT;
      cap_q   <= cap_d;
      meta_q  <= meta_d;
      width_q <= width_d;
      tsc_q   <= tsc_d;
      wr_q    <= wr_d;
    end
  end

  // ---------------- event memory ----------------
  amem_store #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_store (
    .clk        (clk),
    .rst_ni     (resetb_full),
    .wr_en_i    (wr_q),
    .wr_data_i  ({meta_q, width_q, tsc_q}),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_app_channel.sv
module tb_app_channel;
  import app_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TOT_W = 8;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned EW    = 8 + TOT_W + TS_W;

  logic           clk = 1'b0;
  logic           resetb_full = 1'b0;
  logic           rst_init = 1'b0;
  logic           vcomp = 1'b0;
  logic           timeout_enable = 1'b0;
  logic [3:0]     timeout_threshold = '0;
  logic           TOT = 1'b0;
  logic [7:0]     metadata = '0;
  logic           rd_en = 1'b0;
  logic [EW-1:0]  rd_data;
  logic           rd_valid;
  logic [3:0]     count;
  logic           full, empty, overflow, int_reset, busy, timeout_flag;

  always #5 clk = ~clk;

  app_channel #(.DEPTH(DEPTH), .TOT_W(TOT_W), .TS_W(TS_W)) dut (
    .clk               (clk),
    .resetb_full       (resetb_full),
    .rst_init          (rst_init),
    .vcomp             (vcomp),
    .timeout_enable    (timeout_enable),
    .timeout_threshold (timeout_threshold),
    .TOT               (TOT),
    .metadata          (metadata),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .overflow          (overflow),
    .int_reset         (int_reset),
    .busy              (busy),
    .timeout_flag      (timeout_flag)
  );

  // Reference model: cycle count since reset, FIFO of expected events
  logic [TS_W-1:0] ts_model;
  always @(posedge clk) ts_model <= resetb_full ? ts_model + TS_W'(1) : '0;

  logic [EW-1:0] q_model[$];
  logic          ovf_model = 1'b0;
  logic [EW-1:0] last_rd = '0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(q_model.size()));
    chk({tag, "_full"}, 64'(full), 64'(q_model.size() == DEPTH));
    chk({tag, "_empty"}, 64'(empty), 64'(q_model.size() == 0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(ovf_model));
  endtask

  // Drive vcomp high for n cycles and check int_reset / timeout_flag timing
  task automatic vcomp_run(input int n, input bit en, input logic [3:0] thr);
    int  first_ir, first_to, n_ir, n_to, exp_idx;
    bit  to_exp;
    timeout_enable    = en;
    timeout_threshold = thr;
    first_ir = -1; first_to = -1; n_ir = 0; n_to = 0;
    for (int k = 1; k <= n + 8; k++) begin
      vcomp = (k <= n);
      step();
      if (k == 1) chk("busy_on", 64'(busy), 64'(1));
      if (int_reset)    begin n_ir++; if (first_ir < 0) first_ir = k; end
      if (timeout_flag) begin n_to++; if (first_to < 0) first_to = k; end
    end
    // Timeout needs vcomp still high when the counter reaches the threshold
    to_exp  = en && (thr != 0) && (n >= int'(thr) + 1);
    exp_idx = to_exp ? int'(thr) + 2 : n + 2;
    chk("int_reset_count", 64'(n_ir), 64'(1));
    chk("int_reset_cycle", 64'(first_ir), 64'(exp_idx));
    chk("timeout_count", 64'(n_to), to_exp ? 64'(1) : 64'(0));
    if (to_exp) chk("timeout_cycle", 64'(first_to), 64'(exp_idx));
    chk("busy_off", 64'(busy), 64'(0));
  endtask

  // One TOT pulse of n cycles; optionally read on the cycle the event is written
  task automatic tot_pulse(input int n, input logic [7:0] meta, input bit rd_too);
    logic [TS_W-1:0]  ts0;
    logic [TOT_W-1:0] w;
    bit               pv;
    ts0 = ts_model;
    for (int k = 1; k <= n; k++) begin
      TOT = 1'b1;
      metadata = (k == 1) ? meta : 8'($urandom);
      step();
    end
    TOT = 1'b0;
    metadata = 8'($urandom);
    step();
    rd_en = rd_too;
    step();
    rd_en = 1'b0;
    pv = 1'b0;
    if (rd_too && q_model.size() > 0) begin
      last_rd = q_model.pop_front();
      pv = 1'b1;
    end
    w = (n > 255) ? 8'hFF : TOT_W'(n);
    if (q_model.size() < DEPTH) q_model.push_back({meta, w, ts0});
    else ovf_model = 1'b1;
    if (rd_too) begin
      chk("rdw_valid", 64'(rd_valid), 64'(pv));
      chk("rdw_data", 64'(rd_data), 64'(last_rd));
    end
    check_status("pulse");
  endtask

  task automatic do_read();
    bit pv;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    pv = 1'b0;
    if (q_model.size() > 0) begin
      last_rd = q_model.pop_front();
      pv = 1'b1;
    end
    chk("rd_valid", 64'(rd_valid), 64'(pv));
    chk("rd_data", 64'(rd_data), 64'(last_rd));
    step();
    chk("rd_valid_drop", 64'(rd_valid), 64'(0));
    chk("rd_data_hold", 64'(rd_data), 64'(last_rd));
    check_status("read");
  endtask

  int n_ir_init;

  initial begin
    // Reset state
    resetb_full = 1'b0;
    step(); step();
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_int_reset", 64'(int_reset), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout", 64'(timeout_flag), 64'(0));
    check_status("rst");
    resetb_full = 1'b1;
    step();

    // Sequencer: short pulse, timeout, disabled timeouts, random mix
    vcomp_run(5, 1'b1, 4'd10);
    vcomp_run(20, 1'b1, 4'd10);
    vcomp_run(30, 1'b1, 4'd0);
    vcomp_run(30, 1'b0, 4'd10);
    vcomp_run(10, 1'b1, 4'd10);
    vcomp_run(11, 1'b1, 4'd10);
    for (int i = 0; i < 6; i++)
      vcomp_run($urandom_range(1, 25), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // rst_init during INTEG, held against vcomp high
    timeout_enable = 1'b1; timeout_threshold = 4'd10;
    vcomp = 1'b1;
    step(); step();
    chk("init_busy_before", 64'(busy), 64'(1));
    rst_init = 1'b1;
    step();
    chk("init_busy_after", 64'(busy), 64'(0));
    n_ir_init = int'(int_reset);
    rst_init = 1'b0;
    vcomp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_ir_init += int'(int_reset);
    end
    chk("init_no_int_reset", 64'(n_ir_init), 64'(0));
    chk("init_busy_idle", 64'(busy), 64'(0));

    // Single TOT pulse and readback
    tot_pulse(3, 8'hA5, 1'b0);
    do_read();
    do_read();  // empty read is ignored

    // Fill past depth, including a saturating pulse
    for (int i = 0; i < 9; i++)
      tot_pulse((i == 4) ? 260 : $urandom_range(1, 5), 8'($urandom), 1'b0);
    tot_pulse(2, 8'h3C, 1'b1);  // read during write while full
    for (int i = 0; i < 9; i++) do_read();

    // Write with simultaneous read on an empty memory
    tot_pulse(4, 8'h5A, 1'b1);

    // Random mix of pulses and reads
    for (int i = 0; i < 14; i++) begin
      tot_pulse($urandom_range(1, 6), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) do_read();
    end

    // Full reset in the middle of a TOT pulse
    tot_pulse(2, 8'h11, 1'b0);
    TOT = 1'b1; metadata = 8'h77;
    step(); step();
    resetb_full = 1'b0;
    step();
    resetb_full = 1'b1;
    q_model.delete();
    ovf_model = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 3; i++) step();
    TOT = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_status("midrst");
    chk("midrst_rd_data", 64'(rd_data), 64'(0));
    tot_pulse(2, 8'h99, 1'b0);
    do_read();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
